// File: rtl/flags_pkg.sv
// Shared types for the condition-flag path: ALU opcode encoding and the
// architectural NZCV flag word.
package flags_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOGIC = 2'b10,
        OP_MOV   = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};

endpackage

// File: rtl/flag_calc.sv
// Combinational NZCV generator: derives the next flag word from one ALU
// result, keeping C/V from the current flags for LOGIC and MOV.
module flag_calc
    import flags_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  logic             carry,
    input  flags_t           cur,
    output flags_t           nxt
);

    localparam int MSB = WIDTH - 1;

    // Overflow only looks at sign bits; the low operand bits are intentionally dropped.
    logic unused_low_bits;
    assign unused_low_bits = ^{a[MSB-1:0], b[MSB-1:0]};

    always_comb begin
        nxt   = cur;
        nxt.n = result[MSB];
        nxt.z = (result == '0);
        case (op)
            OP_ADD: begin
                nxt.c = carry;
                nxt.v = (a[MSB] == b[MSB]) & (result[MSB] != a[MSB]);
            end
            OP_SUB: begin
                nxt.c = carry;
                nxt.v = (a[MSB] != b[MSB]) & (result[MSB] != a[MSB]);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/flag_register_unit.sv
// Execute-stage flag producer: captures the ALU result, computes NZCV in the
// following cycle, forwards in-flight flags and commits them architecturally.
module flag_register_unit
    import flags_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_out,
    input  logic             set_flags,
    input  logic             cond_ex,
    input  logic             stall,
    input  logic             flush,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             fwd_N,
    output logic             fwd_Z,
    output logic             fwd_C,
    output logic             fwd_V,
    output logic             pending
);

    alu_op_t          op_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic             carry_q;
    logic             valid_q;
    logic             wr_q;
    flags_t           arch_q;
    flags_t           calc;
    flags_t           fwd;
    logic             commit_sel;

    // Pipeline control: stall freezes stage 1 and blocks the commit; flush
    // empties stage 1 at the edge and overrides stall; reset overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
        end else if (!stall) begin
            valid_q <= valid_in;
            wr_q    <= valid_in & set_flags & cond_ex;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            op_q     <= alu_op_t'(alu_op);
            a_q      <= a;
            b_q      <= b;
            result_q <= result;
            carry_q  <= carry_out;
        end
    end

    flag_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (result_q),
        .carry  (carry_q),
        .cur    (arch_q),
        .nxt    (calc)
    );

    assign commit_sel = valid_q & wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            arch_q <= FLAGS_RESET;
        end else if (commit_sel && !stall && !flush) begin
            arch_q <= calc;
        end
    end

    assign fwd     = commit_sel ? calc : arch_q;
    assign pending = commit_sel;

    assign N     = arch_q.n;
    assign Z     = arch_q.z;
    assign C     = arch_q.c;
    assign V     = arch_q.v;
    assign fwd_N = fwd.n;
    assign fwd_Z = fwd.z;
    assign fwd_C = fwd.c;
    assign fwd_V = fwd.v;

endmodule

// File: tb/tb_flag_register_unit.sv
// Bench for flag_register_unit: directed scenarios from the flag rules plus a
// randomized run against an in-order sequential flag model.
module tb_flag_register_unit;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid_in = 1'b0;
    logic [1:0]   alu_op = 2'b00;
    logic [W-1:0] a = '0, b = '0, result = '0;
    logic         carry_out = 1'b0;
    logic         set_flags = 1'b0;
    logic         cond_ex = 1'b0;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic         N, Z, C, V, fwd_N, fwd_Z, fwd_C, fwd_V, pending;

    logic [3:0] arch_w, fwd_w;
    assign arch_w = {N, Z, C, V};
    assign fwd_w  = {fwd_N, fwd_Z, fwd_C, fwd_V};

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    flag_register_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .alu_op(alu_op),
        .a(a), .b(b), .result(result), .carry_out(carry_out),
        .set_flags(set_flags), .cond_ex(cond_ex), .stall(stall), .flush(flush),
        .N(N), .Z(Z), .C(C), .V(V),
        .fwd_N(fwd_N), .fwd_Z(fwd_Z), .fwd_C(fwd_C), .fwd_V(fwd_V),
        .pending(pending)
    );

    // ---------------- reference model ----------------
    // Flags as an in-order machine would leave them: signed overflow is
    // judged by doing the arithmetic in 64 bits.
    function automatic logic [3:0] ref_flags(input logic [1:0] op, input logic [W-1:0] ra,
                                             input logic [W-1:0] rb, input logic [W-1:0] rres,
                                             input logic rc, input logic [3:0] prev);
        longint sa = longint'($signed(ra));
        longint sb = longint'($signed(rb));
        longint s;
        logic fn, fz, fc, fv;
        fn = rres[W-1];
        fz = (rres == '0);
        fc = prev[1];
        fv = prev[0];
        if (op == 2'b00) begin
            s  = sa + sb;
            fc = rc;
            fv = (s > SMAX) || (s < SMIN);
        end else if (op == 2'b01) begin
            s  = sa - sb;
            fc = rc;
            fv = (s > SMAX) || (s < SMIN);
        end
        return {fn, fz, fc, fv};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ires, input logic ic, input logic iv,
                         input logic isf, input logic ice);
        alu_op = op; a = ia; b = ib; result = ires; carry_out = ic;
        valid_in = iv; set_flags = isf; cond_ex = ice;
    endtask

    task automatic idle();
        drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
              1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic gen_random(output logic [1:0] op, output logic [W-1:0] ga, output logic [W-1:0] gb,
                              output logic [W-1:0] gres, output logic gc);
        logic [W:0] wide;
        op = 2'($urandom_range(0, 3));
        ga = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
        gb = ($urandom_range(0, 3) == 0) ? ga : W'($urandom);
        gc = 1'($urandom_range(0, 1));
        case (op)
            2'b00: begin wide = {1'b0, ga} + {1'b0, gb}; gres = wide[W-1:0]; gc = wide[W]; end
            2'b01: begin gres = ga - gb; gc = (ga >= gb); end
            2'b10: gres = ga & gb;
            default: gres = gb;
        endcase
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        idle();
        n_checks++; if (arch_w !== 4'b0000) $display("FAIL reset_arch: got %b want 0000", arch_w); else n_pass++;
        n_checks++; if (fwd_w !== 4'b0000) $display("FAIL reset_fwd: got %b want 0000", fwd_w); else n_pass++;
        n_checks++; if (pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", pending); else n_pass++;
    endtask

    task automatic test_add_overflow();
        drive(2'b00, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        n_checks++; if (fwd_w !== 4'b1001) $display("FAIL add_ovf_fwd: got %b want 1001", fwd_w); else n_pass++;
        n_checks++; if (pending !== 1'b1) $display("FAIL add_ovf_pending: got %b want 1", pending); else n_pass++;
        n_checks++; if (arch_w !== 4'b0000) $display("FAIL add_ovf_arch_early: got %b want 0000", arch_w); else n_pass++;
        tick();
        n_checks++; if (arch_w !== 4'b1001) $display("FAIL add_ovf_arch: got %b want 1001", arch_w); else n_pass++;
        n_checks++; if (pending !== 1'b0) $display("FAIL add_ovf_pending_after: got %b want 0", pending); else n_pass++;
    endtask

    task automatic test_sub_logic();
        drive(2'b01, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++; if (fwd_w !== 4'b0110) $display("FAIL sub_eq_fwd: got %b want 0110", fwd_w); else n_pass++;
        drive(2'b10, $urandom, $urandom, 32'h1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        n_checks++; if (arch_w !== 4'b0110) $display("FAIL sub_eq_arch: got %b want 0110", arch_w); else n_pass++;
        n_checks++; if (fwd_w !== 4'b0010) $display("FAIL logic_fwd: got %b want 0010", fwd_w); else n_pass++;
        tick();
        n_checks++; if (arch_w !== 4'b0010) $display("FAIL logic_arch: got %b want 0010", arch_w); else n_pass++;
    endtask

    task automatic test_cond_fail();
        drive(2'b01, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        n_checks++; if (pending !== 1'b0) $display("FAIL cond_fail_pending: got %b want 0", pending); else n_pass++;
        n_checks++; if (fwd_w !== 4'b0010) $display("FAIL cond_fail_fwd: got %b want 0010", fwd_w); else n_pass++;
        tick();
        n_checks++; if (arch_w !== 4'b0010) $display("FAIL cond_fail_arch: got %b want 0010", arch_w); else n_pass++;
    endtask

    task automatic test_stall();
        drive(2'b00, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        stall = 1'b1;
        idle();
        n_checks++; if (fwd_w !== 4'b0000) $display("FAIL stall_fwd_start: got %b want 0000", fwd_w); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (arch_w !== 4'b0010) $display("FAIL stall_arch_%0d: got %b want 0010", i, arch_w); else n_pass++;
            n_checks++; if (fwd_w !== 4'b0000) $display("FAIL stall_fwd_%0d: got %b want 0000", i, fwd_w); else n_pass++;
            n_checks++; if (pending !== 1'b1) $display("FAIL stall_pending_%0d: got %b want 1", i, pending); else n_pass++;
        end
        stall = 1'b0;
        tick();
        n_checks++; if (arch_w !== 4'b0000) $display("FAIL stall_release_arch: got %b want 0000", arch_w); else n_pass++;
        n_checks++; if (pending !== 1'b0) $display("FAIL stall_release_pending: got %b want 0", pending); else n_pass++;
    endtask

    task automatic test_flush();
        drive(2'b00, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        stall = 1'b1;
        idle();
        n_checks++; if (fwd_w !== 4'b0110) $display("FAIL flush_fwd_before: got %b want 0110", fwd_w); else n_pass++;
        tick();
        n_checks++; if (pending !== 1'b1) $display("FAIL flush_pending_stalled: got %b want 1", pending); else n_pass++;
        flush = 1'b1;
        drive(2'b01, 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        flush = 1'b0;
        stall = 1'b0;
        idle();
        n_checks++; if (pending !== 1'b0) $display("FAIL flush_pending: got %b want 0", pending); else n_pass++;
        n_checks++; if (fwd_w !== 4'b0000) $display("FAIL flush_fwd: got %b want 0000", fwd_w); else n_pass++;
        n_checks++; if (arch_w !== 4'b0000) $display("FAIL flush_arch: got %b want 0000", arch_w); else n_pass++;
        tick();
        n_checks++; if (arch_w !== 4'b0000) $display("FAIL flush_arch_later: got %b want 0000", arch_w); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        drive(2'b01, 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (fwd_w !== 4'b0100) $display("FAIL b2b_fwd0: got %b want 0100", fwd_w); else n_pass++;
        tick();
        idle();
        n_checks++; if (fwd_w !== 4'b1010) $display("FAIL b2b_fwd1: got %b want 1010", fwd_w); else n_pass++;
        n_checks++; if (arch_w !== 4'b0100) $display("FAIL b2b_arch0: got %b want 0100", arch_w); else n_pass++;
        tick();
        n_checks++; if (arch_w !== 4'b1010) $display("FAIL b2b_arch1: got %b want 1010", arch_w); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(2'b00, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++; if (pending !== 1'b1) $display("FAIL rst_mid_pending_before: got %b want 1", pending); else n_pass++;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        n_checks++; if (arch_w !== 4'b0000) $display("FAIL rst_mid_arch: got %b want 0000", arch_w); else n_pass++;
        n_checks++; if (pending !== 1'b0) $display("FAIL rst_mid_pending: got %b want 0", pending); else n_pass++;
        n_checks++; if (fwd_w !== 4'b0000) $display("FAIL rst_mid_fwd: got %b want 0000", fwd_w); else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [W-1:0] ra, rb, rres;
        logic         rc, iv, isf, ice, wr;
        logic [3:0]   model_flags, arch_exp, cap_exp, e;
        logic         cap_wr;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        model_flags = 4'b0000;
        arch_exp    = 4'b0000;
        cap_exp     = 4'b0000;
        cap_wr      = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            gen_random(op, ra, rb, rres, rc);
            iv  = ($urandom_range(0, 4) != 0);
            isf = ($urandom_range(0, 3) != 0);
            ice = ($urandom_range(0, 3) != 0);
            wr  = iv & isf & ice;
            e   = 4'b0000;
            if (wr) begin
                e = ref_flags(op, ra, rb, rres, rc, model_flags);
                model_flags = e;
                exp_q.push_back(e);
            end
            drive(op, ra, rb, rres, rc, iv, isf, ice);
            @(posedge clk);
            if (cap_wr && exp_q.size() > 0) arch_exp = exp_q.pop_front();
            cap_wr  = wr;
            cap_exp = e;
            @(negedge clk);
            n_checks++; if (arch_w !== arch_exp) $display("FAIL rand_arch[%0d]: got %b want %b", i, arch_w, arch_exp); else n_pass++;
            n_checks++; if (fwd_w !== (cap_wr ? cap_exp : arch_exp)) $display("FAIL rand_fwd[%0d]: got %b want %b", i, fwd_w, (cap_wr ? cap_exp : arch_exp)); else n_pass++;
            n_checks++; if (pending !== cap_wr) $display("FAIL rand_pending[%0d]: got %b want %b", i, pending, cap_wr); else n_pass++;
        end
        idle();
        tick();
        if (cap_wr && exp_q.size() > 0) arch_exp = exp_q.pop_front();
        n_checks++; if (arch_w !== arch_exp) $display("FAIL rand_arch_drain: got %b want %b", arch_w, arch_exp); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_add_overflow();
        test_sub_logic();
        test_cond_fail();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flag_register_unit.md
# flag_register_unit

Producer side of the condition-flag path in the execute stage. Generates N/Z/C/V from ALU results, gates updates by the instruction's set-flags bit and its condition outcome, and holds the architectural flags consumed by `condition_checker`. Two-stage internal pipeline: capture, then compute/commit. A forwarding path exposes in-flight flags so a dependent conditional instruction in the next cycle evaluates against up-to-date values.

## Interface
- `WIDTH`, 32: ALU datapath width in bits; minimum 2.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  execute-stage instruction valid.
- `alu_op`  in  2  00 ADD, 01 SUB (a−b), 10 LOGIC, 11 MOV.
- `a`, `b`  in  WIDTH  ALU operands.
- `result`  in  WIDTH  ALU result.
- `carry_out`  in  1  ALU carry; for SUB, 1 means no borrow.
- `set_flags`  in  1  instruction requests a flag update.
- `cond_ex`  in  1  condition passed; from `condition_checker`.
- `stall`  in  1  hold pipeline contents.
- `flush`  in  1  kill the captured instruction.
- `N`, `Z`, `C`, `V`  out  1 each  architectural flags, registered.
- `fwd_N`, `fwd_Z`, `fwd_C`, `fwd_V`  out  1 each  forwarded flags to `condition_checker`.
- `pending`  out  1  stage-1 holds a committing flag write.

## Operation
- Stage 1 capture: on each non-stalled edge, register `alu_op`, `a`, `b`, `result`, and `carry_out`. Also register `wr = valid_in & set_flags & cond_ex`.
- Stage 2 compute, combinational from stage-1 registers:
  - N = result[WIDTH−1].
  - Z = (result == 0).
  - ADD: C = carry_out; V = (a[msb]==b[msb]) & (result[msb]!=a[msb]).
  - SUB: C = carry_out; V = (a[msb]!=b[msb]) & (result[msb]!=a[msb]).
  - LOGIC and MOV: update N and Z only; C and V keep their architectural values.
- Commit: on the edge after capture, if `wr_q` is set and there is no stall or flush, load the computed flags into the architectural register.
- Forward: if `wr_q` is set, `fwd_*` = computed flags; otherwise `fwd_*` = architectural flags. `pending` = `wr_q`.
- `set_flags=1` with `cond_ex=0` makes no change; the instruction flows through with `wr=0`.

## Timing
- Reset (synchronous): N=Z=C=V=0, stage-1 valid and `wr_q` = 0, `pending`=0, so `fwd_*`=0.
- Latency: instruction presented in cycle t is captured at edge t+1. `fwd_*` reflects it during cycle t+1. `N`–`V` update at edge t+2.
- Back-to-back writers: each commits in order, one per cycle. Forwarding always shows the younger instruction's flags.
- Stall:
  - Stage-1 registers hold.
  - No commit.
  - `fwd_*` and `pending` stay stable throughout.
- Flush:
  - Clears `wr_q` and stage-1 valid at the edge.
  - The captured instruction never commits.
  - The architectural flags are unchanged.
- Flush together with stall: flush wins, and the entry is dropped.
- Reset mid-operation: any pending write is discarded, and flags return to 0 at that edge.
- `valid_in` low: `wr` is captured as 0, so nothing commits.

## Structure
- Shared `flags_pkg`:
  - `alu_op_t` enum: ADD, SUB, LOGIC, MOV.
  - `flags_t` packed struct {N, Z, C, V}.
  - `FLAGS_RESET` constant.
- Sub-module `flag_calc`: purely combinational. Inputs are op, a, b, result, carry, and current `flags_t`; output is next `flags_t`. Unit-testable alone.
- Top level contains the stage-1 registers, the architectural register, the forward mux, and stall/flush control.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs -> `N`/`Z`/`C`/`V`=0, `fwd_*`=0, `pending`=0.
- ADD overflow: a=0x7FFFFFFF, b=1, result=0x80000000, carry=0, set_flags=1, cond_ex=1 at t -> cycle t+1 `fwd` N=1 Z=0 C=0 V=1, `pending`=1; after edge t+2 architectural flags are the same.
- SUB equal: a=5, b=5, result=0, carry=1 -> Z=1, C=1, N=0, V=0. A following LOGIC with result=0x00000001 -> N=0, Z=0, C=1 retained, V=0 retained.
- Condition failed: SUB with result=0, set_flags=1, cond_ex=0 -> `pending`=0; flags unchanged from their prior value.
- Stall/flush:
  - Capture an ADD writer, then hold `stall` for 2 cycles -> no commit and `fwd_*` stable; the commit occurs at the first edge after release.
  - Repeat with `flush` asserted during the stall -> no commit, and `pending` drops the next cycle.
- Back-to-back: ADD (result 0) then SUB (result 0x80000000) in consecutive cycles -> `fwd` Z=1, then N=1; architectural flags follow one cycle later each.
